// File: rtl/vjtag_regbank_ctrl.sv
// Virtual-JTAG register bank controller: tck-side scan/IR decode with an
// auto-incrementing pointer, one transaction in flight to the clk-side bank FSM.
module vjtag_regbank_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              tck,
  input  logic              clk,
  input  logic              aclr,
  input  logic              tdi,
  input  logic [1:0]        ir_in,
  input  logic              v_cdr,
  input  logic              v_sdr,
  input  logic              v_udr,
  output logic              tdo,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam logic [1:0] IR_BYP   = 2'd0;
  localparam logic [1:0] IR_ADDR  = 2'd1;
  localparam logic [1:0] IR_WRITE = 2'd2;
  localparam logic [1:0] IR_READ  = 2'd3;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_CAP} state_t;

  // tck domain
  logic [DATA_W:0]   sr_q, sr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ovr_q, ovr_d;
  logic              req_t_q, req_t_d;
  logic              hold_wr_q, hold_wr_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic              byp_q;
  logic              ack_s1_q, ack_s2_q;

  // clk domain
  state_t            state_q, state_d;
  logic              req_s1_q, req_s2_q, req_s3_q;
  logic              ack_t_q, ack_t_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              req_edge;

  assign busy = req_t_q ^ ack_s2_q;
  assign tdo  = (ir_in == IR_BYP) ? byp_q : sr_q[0];

  always_comb begin
    sr_d         = sr_q;
    ptr_d        = ptr_q;
    ovr_d        = ovr_q;
    req_t_d      = req_t_q;
    hold_wr_d    = hold_wr_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    if (v_udr) begin
      if (ir_in != IR_BYP) begin
        if (busy) begin
          ovr_d = 1'b1;
        end else begin
          req_t_d = ~req_t_q;
          case (ir_in)
            IR_ADDR: begin
              ptr_d       = sr_q[ADDR_W-1:0];
              hold_wr_d   = 1'b0;
              hold_addr_d = sr_q[ADDR_W-1:0];
            end
            IR_WRITE: begin
              ptr_d        = ptr_q + ADDR_ONE;
              hold_wr_d    = 1'b1;
              hold_addr_d  = ptr_q;
              hold_wdata_d = sr_q[DATA_W-1:0];
            end
            default: begin
              // READ prefetches the next location for the following capture
              ptr_d       = ptr_q + ADDR_ONE;
              hold_wr_d   = 1'b0;
              hold_addr_d = ptr_q + ADDR_ONE;
            end
          endcase
        end
      end
    end else if (v_cdr) begin
      if (ir_in == IR_READ) begin
        // rd_buf is quasi-static here: it only changes while busy is high
        sr_d  = {ovr_q, rd_buf_q};
        ovr_d = 1'b0;
      end
    end else if (v_sdr) begin
      if (ir_in == IR_READ)
        sr_d = {tdi, sr_q[DATA_W:1]};
      else if (ir_in != IR_BYP)
        sr_d = {sr_q[DATA_W], tdi, sr_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      sr_q         <= '0;
      ptr_q        <= '0;
      ovr_q        <= 1'b0;
      req_t_q      <= 1'b0;
      hold_wr_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      byp_q        <= 1'b0;
      ack_s1_q     <= 1'b0;
      ack_s2_q     <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      ptr_q        <= ptr_d;
      ovr_q        <= ovr_d;
      req_t_q      <= req_t_d;
      hold_wr_q    <= hold_wr_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      byp_q        <= tdi;
      ack_s1_q     <= ack_t_q;
      ack_s2_q     <= ack_s1_q;
    end
  end

  assign req_edge  = req_s2_q ^ req_s3_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    ack_t_d  = ack_t_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_buf_d = rd_buf_q;
    reg_we   = 1'b0;
    reg_re   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_edge) begin
          // hold regs are stable for the whole transaction
          addr_d  = hold_addr_q;
          wdata_d = hold_wdata_q;
          state_d = hold_wr_q ? S_WR : S_RD;
        end
      end
      S_WR: begin
        reg_we  = 1'b1;
        ack_t_d = ~ack_t_q;
        state_d = S_IDLE;
      end
      S_RD: begin
        reg_re  = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        rd_buf_d = reg_rdata;
        ack_t_d  = ~ack_t_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q  <= S_IDLE;
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      req_s3_q <= 1'b0;
      ack_t_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      req_s1_q <= req_t_q;
      req_s2_q <= req_s1_q;
      req_s3_q <= req_s2_q;
      ack_t_q  <= ack_t_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_buf_q <= rd_buf_d;
    end
  end

endmodule

// File: doc/vjtag_regbank_ctrl.md
# vjtag_regbank_ctrl

Controller that sequences host accesses over a virtual JTAG instance into a bank of up to 2^ADDR_W system registers. It decodes a 2-bit IR into bypass, address-load, write and read operations, and maintains an auto-incrementing address pointer. Each completed DR update becomes one transaction, carried from the tck domain to the clk domain by a toggle request/acknowledge handshake. It sits between the virtual JTAG hub signals and the system-side register bank.

## Interface
- DATA_W, 8, register data width; must be ≥ ADDR_W.
- ADDR_W, 4, register address width.
- tck  in  1  JTAG clock; all JTAG-side logic uses its rising edge.
- clk  in  1  system clock; all bank-side logic uses its rising edge.
- aclr  in  1  reset, asynchronous, active-high; clears both domains.
- tdi  in  1  serial data in.
- ir_in  in  2  instruction: 0 BYPASS, 1 ADDR, 2 WRITE, 3 READ.
- v_cdr  in  1  Capture-DR state, sampled at tck.
- v_sdr  in  1  Shift-DR state, sampled at tck.
- v_udr  in  1  Update-DR state, sampled at tck.
- tdo  out  1  serial data out.
- reg_addr  out  ADDR_W  bank address (clk domain).
- reg_wdata  out  DATA_W  bank write data (clk domain).
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read strobe.
- reg_rdata  in  DATA_W  bank read data, valid the clk after reg_re.
- busy  out  1  tck domain: transaction outstanding.

## Operation
- Shift register `sr`: DATA_W+1 bits. When v_sdr is high, sr shifts right at each tck.
  - IR 1 and IR 2 (length DATA_W): tdi enters bit DATA_W-1.
  - IR 3 (length DATA_W+1): tdi enters bit DATA_W.
- IR 0: one-bit bypass register loads tdi every tck.
- tdo is combinational. IR 0 drives the bypass register; any other IR drives sr[0].
- Capture (v_cdr high at tck):
  - IR 3: sr ← {overrun, rd_buf}, and overrun clears.
  - Other IRs: sr is unchanged.
- Update (v_udr high at tck) with busy low issues exactly one transaction:
  - ADDR: ptr ← sr[ADDR_W-1:0]. Then issue FETCH at the new ptr.
  - WRITE: issue WRITE(ptr, sr[DATA_W-1:0]). Then ptr ← ptr+1. No fetch.
  - READ: ptr ← ptr+1. Then issue FETCH at the new ptr (prefetch for the next READ capture).
  - BYPASS: no action.
- ptr wraps modulo 2^ADDR_W.
- Issuing a transaction: latch op, addr and wdata into hold registers, toggle req_t, set busy.
- Update while busy: the transaction is dropped, ptr is unchanged, and the sticky overrun flag sets.
- Clk side: a 2-FF synchronizer on req_t, followed by an edge detect. FSM states:
  - IDLE → on edge, drive reg_addr/reg_wdata from the hold registers (stable, quasi-static).
    - WRITE op → WR.
    - FETCH op → RD.
  - WR: reg_we=1 for one clk. Toggle ack_t. → IDLE.
  - RD: reg_re=1. → CAP.
  - CAP: rd_buf ← reg_rdata. Toggle ack_t. → IDLE.
- Tck side: a 2-FF synchronizer on ack_t. busy = (req_t ≠ ack_sync).
- rd_buf is read in the tck domain only while busy is low.
- A READ capture after WRITEs returns stale data. The host issues ADDR before reading back.

## Timing
- Reset values:
  - tdo 0, busy 0, reg_we 0, reg_re 0, reg_addr 0, reg_wdata 0.
  - ptr 0, rd_buf 0, overrun 0, sr 0, bypass 0, req_t/ack_t 0.
  - FSM IDLE.
- aclr mid-transaction: both toggles clear. The pending op is abandoned with no strobe, and busy is 0 after release.
- Req latency: reg_we, or reg_re, asserts on the 3rd clk edge after the req_t toggle. Clk cycles 1–2 are synchronizer, cycle 3 is edge detect plus the state move.
- Capture: rd_buf is valid 2 clk after reg_re asserts.
- Ack latency: busy falls on the 2nd tck edge after ack_t toggles.
- Strobes are exactly one clk wide. At most one transaction is in flight.
- v_cdr, v_sdr and v_udr are mutually exclusive. If more than one is asserted, the priority is udr > cdr > sdr.

## Test plan
- Reset, then ADDR=0x05 → one reg_re at addr 5; bank returns 0x3C; busy falls. The next READ scan-out yields 9'h03C.
- ADDR=0x0F, then WRITE 0xA1, then WRITE 0xB2 → reg_we at addr 15 with 0xA1, then reg_we at addr 0 with 0xB2 (wrap); ptr=1.
- ADDR=2, then three READ scans over a bank of {2:0x11, 3:0x22, 4:0x33} → scan-outs 0x11, 0x22, 0x33; each READ update prefetches ptr+1.
- Slow clk (tck:clk = 8:1): two WRITE updates 2 tck apart → only the first produces reg_we; the next READ capture has MSB=1; a second READ capture has MSB=0.
- IR=0 scan of 10 bits → tdo equals tdi delayed by 1 tck; no strobes; ptr unchanged.
- Assert aclr one clk after the WRITE req toggle → no reg_we; busy=0; ptr=0; outputs at reset values.
